// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring shift-subtract divide on operand
// magnitudes, with the sign applied to the final value. Divide special cases
// (divide by zero, signed overflow) complete one cycle after accept.
// Optional build macro: MULDIV_FAST_MUL_EN -- MUL* ops use one combinational
// multiply and also complete one cycle after accept.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL1    = '1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [2:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic             neg_q;
  // hi: product high half / partial remainder; lo: multiplier / dividend->quotient
  logic [XLEN-1:0]  hi, lo, dvs;

  // ---- accept-side decode ----
  logic            a_sgn, b_sgn, a_neg, b_neg, sign_in;
  logic            b_zero, ovf, special;
  logic [XLEN-1:0] a_abs, b_abs, spec_res, fast_res;

  assign a_sgn   = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
  assign b_sgn   = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
  assign a_neg   = a_sgn & a[XLEN-1];
  assign b_neg   = b_sgn & b[XLEN-1];
  assign a_abs   = a_neg ? -a : a;
  assign b_abs   = b_neg ? -b : b;
  // remainder follows the dividend; everything else is the product of signs
  assign sign_in = (op == 3'd6) ? a_neg : (a_neg ^ b_neg);
  assign b_zero  = (b == '0);
  assign ovf     = ~op[0] & (a == INT_MIN) & (b == ALL1);
  assign special = op[2] & (b_zero | ovf);
  assign spec_res = b_zero ? (op[1] ? a : ALL1) : (op[1] ? '0 : INT_MIN);

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
  logic [2*XLEN-1:0] fast_mag, fast_prod;
  assign fast_mag  = {{XLEN{1'b0}}, a_abs} * {{XLEN{1'b0}}, b_abs};
  assign fast_prod = sign_in ? -fast_mag : fast_mag;
  assign fast_res  = (op[1:0] == 2'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
  localparam bit FAST = 1'b0;
  assign fast_res = '0;
`endif

  // ---- one iteration step ----
  logic [XLEN:0]     mul_sum, trial;
  logic              fits;
  logic [XLEN-1:0]   mh, ml, dh, dl, nh, nl;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, calc_res;

  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
  assign mh      = mul_sum[XLEN:1];
  assign ml      = {mul_sum[0], lo[XLEN-1:1]};
  // partial remainder stays below the divisor, so the shifted value fits XLEN+1 bits
  assign trial   = {hi, lo[XLEN-1]} - {1'b0, dvs};
  assign fits    = ~trial[XLEN];
  assign dh      = fits ? trial[XLEN-1:0] : {hi[XLEN-2:0], lo[XLEN-1]};
  assign dl      = {lo[XLEN-2:0], fits};
  assign nh      = op_q[2] ? dh : mh;
  assign nl      = op_q[2] ? dl : ml;

  // final sign fix-up, valid on the last iteration
  assign prod     = {nh, nl};
  assign prod_s   = neg_q ? -prod : prod;
  assign quo_s    = neg_q ? -nl : nl;
  assign rem_s    = neg_q ? -nh : nh;
  assign calc_res = op_q[2] ? (op_q[1] ? rem_s : quo_s)
                            : ((op_q[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]);

  // control FSM with registered busy/done/result/tag_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      neg_q   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      dvs     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      tag_out <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == CALC) begin
        count <= count + 1'b1;
        hi    <= nh;
        lo    <= nl;
        if (count == CW'(XLEN-1)) begin
          state   <= FIN;
          busy    <= 1'b0;
          done    <= 1'b1;
          result  <= calc_res;
          tag_out <= tag_q;
        end
      end else if (start) begin
        op_q  <= op;
        tag_q <= tag_in;
        neg_q <= sign_in;
        count <= '0;
        hi    <= '0;
        lo    <= op[2] ? a_abs : b_abs;
        dvs   <= op[2] ? b_abs : a_abs;
        if (special) begin
          state   <= FIN;
          done    <= 1'b1;
          result  <= spec_res;
          tag_out <= tag_in;
        end else if (FAST && !op[2]) begin
          state   <= FIN;
          done    <= 1'b1;
          result  <= fast_res;
          tag_out <= tag_in;
        end else begin
          state <= CALC;
          busy  <= 1'b1;
        end
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes model results, a monitor
// pops and compares on every done pulse.
module tb_muldiv_unit;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam logic [31:0] MINV = 32'h8000_0000;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0]       op = '0;
  logic [XLEN-1:0]  a = '0, b = '0;
  logic [TAG_W-1:0] tag_in = '0;
  logic             busy, done;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_out;

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .op(op),
    .a(a), .b(b), .tag_in(tag_in), .busy(busy), .done(done),
    .result(result), .tag_out(tag_out));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] res; logic [4:0] tag; int at; } exp_t;
  exp_t sbq[$];
  int errs = 0, checks = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_tag = '0;

  // reference: RV32M semantics via 64-bit integer arithmetic
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p;
    int xi, yi;
    logic [31:0] r;
    xi = int'(x);
    yi = int'(y);
    sx = (o == 3'd1 || o == 3'd2) ? longint'(xi) : longint'(x);
    sy = (o == 3'd1) ? longint'(yi) : longint'(y);
    p  = sx * sy;
    case (o)
      3'd0:    r = p[31:0];
      3'd1, 3'd2, 3'd3: r = p[63:32];
      3'd4:    r = (y == 0) ? ONES : (x == MINV && y == ONES) ? MINV : 32'(xi / yi);
      3'd5:    r = (y == 0) ? ONES : x / y;
      3'd6:    r = (y == 0) ? x : (x == MINV && y == ONES) ? 32'h0 : 32'(xi % yi);
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic int lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && (y == 0 || (!o[0] && x == MINV && y == ONES))) return 1;
    if (!o[2] && FAST) return 1;
    return XLEN + 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_done: got done=1 want no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", result, e.res);
        chk("tag", 32'(tag_out), 32'(e.tag));
        chk("latency", cyc, e.at);
      end
    end
  end

  // called #1 after an edge with busy==0; returns in cycle 1 of the op
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] t);
    exp_t e;
    int l;
    l = lat(o, x, y);
    op = o; a = x; b = y; tag_in = t; start = 1'b1;
    e.res = model(o, x, y);
    e.tag = t;
    e.at  = cyc + l;
    sbq.push_back(e);
    last_res = e.res;
    last_tag = t;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom; tag_in = 5'($urandom);
    chk("busy_c1", 32'(busy), 32'(l > 1));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!done) begin
      errs++;
      $display("FAIL done_timeout: got done=0 want done within 40 cycles (cycle %0d)", cyc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] prev_res;
    logic [4:0]  prev_tag;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", result, 0);
    chk("rst_tag", 32'(tag_out), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed values, chained back-to-back in each done cycle
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);   wait_done();
    issue(3'd1, MINV, MINV, 5'd1);              wait_done();
    issue(3'd3, ONES, ONES, 5'd2);              wait_done();
    issue(3'd2, 32'hFFFF_FFFE, 32'd3, 5'd3);    wait_done();
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);    wait_done();
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);    wait_done();
    issue(3'd5, 32'd5, 32'd0, 5'd7);            wait_done();
    issue(3'd6, MINV, ONES, 5'd8);              wait_done();
    issue(3'd4, MINV, ONES, 5'd10);             wait_done();
    issue(3'd7, 32'd9, 32'd0, 5'd11);           wait_done();

    // start while busy must be ignored
    issue(3'd5, 32'd1000, 32'd3, 5'd12);
    start = 1'b1; op = 3'd5; a = 32'd50; b = 32'd0; tag_in = 5'd30;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_hold", 32'(busy), 1);
    wait_done();
    @(posedge clk); #1;

    // flush in cycle 10, with a competing start
    prev_res = last_res;
    prev_tag = last_tag;
    issue(3'd5, 32'd100, 32'd7, 5'd9);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1; start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4; tag_in = 5'd1;
    void'(sbq.pop_back());
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    chk("flush_busy", 32'(busy), 0);
    chk("flush_done", 32'(done), 0);
    chk("flush_result", result, prev_res);
    chk("flush_tag", 32'(tag_out), 32'(prev_tag));
    repeat (40) begin @(posedge clk); #1; end
    chk("flush_idle", 32'(busy), 0);

    // reset in cycle 15 of a divide
    issue(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd13);
    repeat (14) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_result", result, 0);
    chk("midrst_tag", 32'(tag_out), 0);
    sbq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(3'd6, 32'd23, 32'd5, 5'd14);          wait_done();

    // randomized ops, always issued back-to-back in the done cycle
    for (int i = 0; i < 25; i++) begin
      logic [2:0]  o;
      logic [31:0] x, y;
      int sel;
      o = 3'($urandom);
      x = $urandom;
      y = $urandom;
      sel = $urandom_range(0, 5);
      if (sel == 0) y = 32'd0;
      else if (sel == 1) begin x = MINV; y = ONES; end
      else if (sel == 2) y = 32'($urandom_range(1, 15));
      else if (sel == 3) y = -32'($urandom_range(1, 15));
      issue(o, x, y, 5'($urandom));
      wait_done();
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("drain", 32'(sbq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
